// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - walks every input vector of a gate under test and checks y_i against TRUTH
// Optional feature macro: GATE_CHECK_FIRST_FAIL_EN (captures the first mismatching vector of a run).
module gate_truth_checker #(
  parameter int                 N_IN   = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 4'b0001,
  parameter int                 SETTLE = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            y_i,
  output logic [N_IN-1:0] a_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      err_cnt,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

  state_t          state;
  logic [N_IN-1:0] vec;
  logic [CW-1:0]   cnt;
  logic            mismatch;
  logic            sample;
  logic [7:0]      err_next;

  assign mismatch = (y_i != TRUTH[vec]);
  assign sample   = (state == DRIVE) && (cnt == CNT_LAST);
  // Saturating count; also feeds pass so a mismatch on the last sample edge is seen.
  assign err_next = (mismatch && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      vec     <= '0;
      cnt     <= '0;
      a_o     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec     <= '0;
            a_o     <= '0;
            cnt     <= '0;
            err_cnt <= 8'd0;
            pass    <= 1'b0;
            busy    <= 1'b1;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (sample) begin
            err_cnt <= err_next;
            if (vec == VEC_LAST) begin
              done  <= 1'b1;
              pass  <= (err_next == 8'd0);
              state <= FINISH;
            end else begin
              vec <= vec + 1'b1;
              a_o <= vec + 1'b1;
              cnt <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          a_o   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATE_CHECK_FIRST_FAIL_EN
  // err_cnt is still zero on the first mismatching sample of a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_vec <= '0;
    end else if (state == IDLE && start) begin
      first_fail_vec <= '0;
    end else if (sample && mismatch && (err_cnt == 8'd0)) begin
      first_fail_vec <= vec;
    end
  end
`else
  assign first_fail_vec = '0;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - scoreboard bench for gate_truth_checker against a truth-table reference model
module tb_gate_truth_checker;

  typedef struct {
    int     err;
    bit     pass;
    int     ffv;
    int     due;
  } exp_t;

  localparam logic [3:0] NOR_TT = 4'b0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start8 = 1'b0;
  logic [3:0] gate_f = NOR_TT;
  logic       y;
  logic [1:0] a;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [1:0] ffv;
  logic [7:0] a8, ffv8, err8;
  logic       busy8, done8, pass8;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int base = 0;
  bit track = 0;
  exp_t q[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign y = gate_f[a];

  gate_truth_checker dut (
    .clk(clk), .rst(rst), .start(start), .y_i(y), .a_o(a), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_fail_vec(ffv)
  );

  gate_truth_checker #(.N_IN(8), .TRUTH(256'd0), .SETTLE(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .y_i(1'b1), .a_o(a8), .busy(busy8), .done(done8),
    .pass(pass8), .err_cnt(err8), .first_fail_vec(ffv8)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: compare expected table with the gate's actual response, vector by vector.
  function automatic exp_t ref_model(input int n, input logic [255:0] truth, input logic [255:0] resp);
    exp_t e;
    int   c = 0;
    bit   found = 0;
    e.ffv = 0;
    for (int v = 0; v < n; v++) begin
      if (truth[v] != resp[v]) begin
        if (!found) e.ffv = v;
        found = 1;
        c++;
      end
    end
    e.err  = (c > 255) ? 255 : c;
    e.pass = (c == 0);
`ifndef GATE_CHECK_FIRST_FAIL_EN
    e.ffv = 0;
`endif
    e.due = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.due);
        chk("err_cnt", err_cnt, e.err);
        chk("pass", pass, e.pass);
        chk("first_fail_vec", ffv, e.ffv);
      end
    end
    if (done8) begin
      if (q8.size() == 0) begin
        chk("spurious_done8", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("done8_cycle", cyc, e.due);
        chk("err8_saturated", err8, e.err);
        chk("pass8", pass8, e.pass);
        chk("first_fail_vec8", ffv8, e.ffv);
      end
    end
  end

  // Vector sequencing: each vector held 3 cycles, last held through DONE, then 0.
  always @(negedge clk) begin
    if (track) begin
      int k;
      k = cyc - base;
      if (k <= 12) begin
        chk("a_o_seq", a, (k < 12) ? k / 3 : 3);
        chk("busy_run", busy, 1);
      end else begin
        chk("a_o_idle", a, 0);
        chk("busy_idle", busy, 0);
        track = 0;
      end
    end
  end

  task automatic wait_drain(input int limit);
    int i;
    for (i = 0; i < limit && q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic run4(input logic [3:0] f, input bit poke);
    exp_t e;
    gate_f = f;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    e = ref_model(4, {252'd0, NOR_TT}, {252'd0, f});
    e.due = cyc + 12;
    q.push_back(e);
    base = cyc;
    track = 1;
    if (poke) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    wait_drain(40);
    repeat (3) @(negedge clk);
    chk("pass_hold", pass, e.pass);
    chk("err_hold", err_cnt, e.err);
  endtask

  initial begin
    #1;
    chk("rst_a_o", a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ffv", ffv, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run4(4'b0001, 0);   // NOR gate: clean pass
    run4(4'b1000, 0);   // AND gate: vectors 0 and 3 mismatch
    run4(4'b0000, 0);   // stuck-at-0
    run4(4'b1111, 0);   // stuck-at-1
    run4(4'b0110, 1);   // start re-pulsed while busy must be ignored
    for (int r = 0; r < 10; r++) run4(4'($urandom_range(0, 15)), r[0]);

    // Abort mid-run with reset.
    gate_f = NOR_TT;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    track = 0;
    q.delete();
    rst = 1'b1;
    #1;
    chk("abort_a_o", a, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err_cnt, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    run4(4'b0001, 0);

    // 8-input walk with saturation.
    begin
      exp_t e;
      int i;
      @(negedge clk); start8 = 1'b1;
      @(negedge clk); start8 = 1'b0;
      e = ref_model(256, 256'd0, {256{1'b1}});
      e.due = cyc + 256;
      q8.push_back(e);
      for (i = 0; i < 400 && q8.size() != 0; i++) @(negedge clk);
      chk("drain8_timeout", q8.size(), 0);
      @(negedge clk);
      chk("busy8_idle", busy8, 0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
